pwm_decoder: RTL and testbench

Measures the high time of an incoming servo-style PWM pulse (e.g. RC receiver channel or loop-back of a wheel PWM line) in 1 µs ticks and converts it to a saturated signed 8-bit wheel command. It is the receive-side counterpart of the wheel PWM generator: same tick base (`one_MHz_enable`), same zero/scale/flip conventions. It sits between an external pin and the drive command mux, and flags loss of signal.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_width_to_cmd.sv | 40 ++++
 rtl/pwm_decoder.sv | 144 ++++++++++++++
 tb/tb_pwm_decoder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared PWM state type, command limits and tick-base constants
package pwm_pkg;

   typedef enum logic [1:0] {
      WAIT_LOW  = 2'd0,
      WAIT_RISE = 2'd1,
      MEASURE   = 2'd2
   } pwm_state_e;

   localparam int CMD_MAX   = 127;
   localparam int CMD_MIN   = -128;

   // Pulse widths are counted in 1 us ticks of one_MHz_enable.
   localparam int PWM_ZERO  = 1500;
   localparam int PWM_SHIFT = 2;
   localparam int WIDTH_W   = 12;

endpackage

// File: rtl/pwm_width_to_cmd.sv
// rtl/pwm_width_to_cmd.sv - combinational pulse width to signed wheel command
// Offset by ZERO, arithmetic shift by SHIFT, saturate to 8 bits, optional negate.
module pwm_width_to_cmd
   import pwm_pkg::*;
#(
   parameter int ZERO    = PWM_ZERO,
   parameter int SHIFT   = PWM_SHIFT,
   parameter bit FLIPPED = 1'b0
) (
   input  logic [WIDTH_W-1:0] width_i,
   output logic signed [7:0]  cmd_o
);

   localparam logic signed [12:0] ZERO_S = 13'(ZERO);
   localparam logic signed [12:0] MAX_S  = 13'(CMD_MAX);
   localparam logic signed [12:0] MIN_S  = 13'(CMD_MIN);

   logic signed [12:0] diff;
   logic signed [12:0] scaled;
   logic signed [7:0]  sat;

   always_comb begin
      diff   = $signed({1'b0, width_i}) - ZERO_S;
      scaled = diff >>> SHIFT;
      if (scaled > MAX_S) begin
         sat = 8'(CMD_MAX);
      end else if (scaled < MIN_S) begin
         sat = 8'(CMD_MIN);
      end else begin
         sat = scaled[7:0];
      end
      // -128 has no positive counterpart in 8 bits, so it folds to +127.
      if (FLIPPED) begin
         cmd_o = (sat == 8'(CMD_MIN)) ? 8'(CMD_MAX) : -sat;
      end else begin
         cmd_o = sat;
      end
   end

endmodule

// File: rtl/pwm_decoder.sv
// rtl/pwm_decoder.sv - servo PWM high-time decoder producing a saturated wheel command
// Optional loss-of-signal watchdog compiled in with PWM_DECODER_TIMEOUT_EN.
module pwm_decoder
   import pwm_pkg::*;
#(
   parameter int ZERO      = PWM_ZERO,
   parameter int SHIFT     = PWM_SHIFT,
   parameter int MIN_WIDTH = 500,
   parameter int MAX_WIDTH = 2500,
   parameter int TIMEOUT   = 50000,
   parameter bit FLIPPED   = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              one_MHz_enable,
   input  logic              pwm_in,
   output logic signed [7:0] wheel_cmd,
   output logic              cmd_valid,
   output logic              pulse_err,
   output logic              signal_lost
);

   localparam logic [WIDTH_W-1:0] MIN_W = WIDTH_W'(MIN_WIDTH);
   localparam logic [WIDTH_W-1:0] MAX_W = WIDTH_W'(MAX_WIDTH);

   // Synchronizer is left unreset so it tracks the pin during reset; WAIT_LOW
   // then sees a pin that is already high and skips the partial pulse.
   logic s1_q, s2_q, s3_q;
   logic rise, fall;

   pwm_state_e         state_q, state_d;
   logic [WIDTH_W-1:0] width_q, width_d;
   logic signed [7:0]  cmd_q, cmd_d;
   logic               valid_q, valid_d;
   logic               err_q, err_d;
   logic               lost_q, lost_d;
   logic               accept;
   logic signed [7:0]  eval_cmd;

   always_ff @(posedge clk) begin
      s1_q <= pwm_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
   end

   assign rise = s2_q & ~s3_q;
   assign fall = ~s2_q & s3_q;

   pwm_width_to_cmd #(
      .ZERO    (ZERO),
      .SHIFT   (SHIFT),
      .FLIPPED (FLIPPED)
   ) u_to_cmd (
      .width_i (width_q),
      .cmd_o   (eval_cmd)
   );

`ifdef PWM_DECODER_TIMEOUT_EN
   localparam logic [15:0] TO = 16'(TIMEOUT);
   logic [15:0] wd_q, wd_d;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT;
`endif

   always_comb begin
      state_d = state_q;
      width_d = width_q;
      cmd_d   = cmd_q;
      valid_d = 1'b0;
      err_d   = 1'b0;
      lost_d  = lost_q;
      accept  = 1'b0;
      case (state_q)
         WAIT_LOW: begin
            if (!s2_q) state_d = WAIT_RISE;
         end
         WAIT_RISE: begin
            if (rise) begin
               width_d = '0;
               state_d = MEASURE;
            end
         end
         MEASURE: begin
            if (width_q > MAX_W) begin
               err_d   = 1'b1;
               state_d = WAIT_LOW;
            end else if (fall) begin
               state_d = WAIT_RISE;
               accept  = (width_q >= MIN_W);
            end else if (one_MHz_enable) begin
               width_d = width_q + WIDTH_W'(1);
            end
         end
         default: state_d = WAIT_LOW;
      endcase
      if (accept) begin
         cmd_d   = eval_cmd;
         valid_d = 1'b1;
         lost_d  = 1'b0;
      end
`ifdef PWM_DECODER_TIMEOUT_EN
      wd_d = wd_q;
      if (accept) begin
         wd_d = '0;
      end else if (wd_q == TO) begin
         lost_d = 1'b1;
         cmd_d  = '0;
      end else if (one_MHz_enable) begin
         wd_d = wd_q + 16'd1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= WAIT_LOW;
         width_q <= '0;
         cmd_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         lost_q  <= 1'b1;
`ifdef PWM_DECODER_TIMEOUT_EN
         wd_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         width_q <= width_d;
         cmd_q   <= cmd_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         lost_q  <= lost_d;
`ifdef PWM_DECODER_TIMEOUT_EN
         wd_q    <= wd_d;
`endif
      end
   end

   assign wheel_cmd   = cmd_q;
   assign cmd_valid   = valid_q;
   assign pulse_err   = err_q;
   assign signal_lost = lost_q;

endmodule

// File: tb/tb_pwm_decoder.sv
// tb/tb_pwm_decoder.sv - directed vector bench for pwm_decoder (normal and flipped instances)
// Covers the watchdog sequence when built with PWM_DECODER_TIMEOUT_EN.
module tb_pwm_decoder;

   typedef struct {
      string name;
      int    width;
      bit    tick_on;
      int    gap;
      int    exp_valid;
      int    exp_err;
      int    exp_cmd;
      int    exp_cmd_f;
   } vec_t;

   localparam int GAP = 150;
`ifdef PWM_DECODER_TIMEOUT_EN
   localparam int PERIOD_LOW = GAP;
`else
   localparam int PERIOD_LOW = 18500;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic tick = 1'b1;
   logic pwm = 1'b0;

   logic signed [7:0] cmd, cmd_f;
   logic valid, err, lost, valid_f, err_f, lost_f;

   int n_checks = 0;
   int n_pass = 0;
   int n_valid = 0, n_err = 0, n_valid_f = 0, n_err_f = 0, n_both = 0;

   vec_t vecs [15];

   always #5 clk = ~clk;

   pwm_decoder dut (
      .clk            (clk),
      .reset          (reset),
      .one_MHz_enable (tick),
      .pwm_in         (pwm),
      .wheel_cmd      (cmd),
      .cmd_valid      (valid),
      .pulse_err      (err),
      .signal_lost    (lost)
   );

   pwm_decoder #(.FLIPPED(1'b1)) dut_f (
      .clk            (clk),
      .reset          (reset),
      .one_MHz_enable (tick),
      .pwm_in         (pwm),
      .wheel_cmd      (cmd_f),
      .cmd_valid      (valid_f),
      .pulse_err      (err_f),
      .signal_lost    (lost_f)
   );

   always @(negedge clk) begin
      if (valid)   n_valid++;
      if (err)     n_err++;
      if (valid_f) n_valid_f++;
      if (err_f)   n_err_f++;
      if ((valid && err) || (valid_f && err_f)) n_both++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   // The rise cycle's tick is never counted, so a W-tick measurement needs W+1 high cycles.
   task automatic drive_pulse(input int w, input bit tick_on);
      @(posedge clk);
      #1 pwm = 1'b1;
      tick = tick_on;
      repeat (w + 1) @(posedge clk);
      #1 pwm = 1'b0;
      tick = 1'b1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
   endtask

   initial begin
      int v0, e0, vf0, ef0;
      bit seen;

      vecs[0]  = '{"period1500", 1500, 1'b1, PERIOD_LOW, 1, 0,    0,    0};
      vecs[1]  = '{"w2000",      2000, 1'b1, GAP,        1, 0,  125, -125};
      vecs[2]  = '{"glitch400",   400, 1'b1, GAP,        0, 0,  125, -125};
      vecs[3]  = '{"w2000b",     2000, 1'b1, GAP,        1, 0,  125, -125};
      vecs[4]  = '{"w2100",      2100, 1'b1, GAP,        1, 0,  127, -127};
      vecs[5]  = '{"w1000",      1000, 1'b1, GAP,        1, 0, -125,  125};
      vecs[6]  = '{"over2600",   2600, 1'b1, GAP,        0, 1, -125,  125};
      vecs[7]  = '{"w499",        499, 1'b1, GAP,        0, 0, -125,  125};
      vecs[8]  = '{"w500",        500, 1'b1, GAP,        1, 0, -128,  127};
      vecs[9]  = '{"w2500",      2500, 1'b1, GAP,        1, 0,  127, -127};
      vecs[10] = '{"over2501",   2501, 1'b1, GAP,        0, 1,  127, -127};
      vecs[11] = '{"w1501",      1501, 1'b1, GAP,        1, 0,    0,    0};
      vecs[12] = '{"w1499",      1499, 1'b1, GAP,        1, 0,   -1,    1};
      vecs[13] = '{"notick1000", 1000, 1'b0, GAP,        0, 0,   -1,    1};
      vecs[14] = '{"w1800",      1800, 1'b1, GAP,        1, 0,   75,  -75};

      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_cmd",   int'(cmd), 0);
      check("reset_valid", int'(valid), 0);
      check("reset_err",   int'(err), 0);
      check("reset_lost",  int'(lost), 1);
      idle(10);

      foreach (vecs[i]) begin
         v0 = n_valid; e0 = n_err; vf0 = n_valid_f; ef0 = n_err_f;
         drive_pulse(vecs[i].width, vecs[i].tick_on);
         idle(vecs[i].gap);
         @(negedge clk);
         check({vecs[i].name, "_valid"},   n_valid - v0,   vecs[i].exp_valid);
         check({vecs[i].name, "_err"},     n_err - e0,     vecs[i].exp_err);
         check({vecs[i].name, "_cmd"},     int'(cmd),      vecs[i].exp_cmd);
         check({vecs[i].name, "_valid_f"}, n_valid_f - vf0, vecs[i].exp_valid);
         check({vecs[i].name, "_err_f"},   n_err_f - ef0,  vecs[i].exp_err);
         check({vecs[i].name, "_cmd_f"},   int'(cmd_f),    vecs[i].exp_cmd_f);
         check({vecs[i].name, "_lost"},    int'(lost),     0);
      end

      // Fall first sampled at the next edge; cmd_valid appears two edges later.
      drive_pulse(2000, 1'b1);
      @(posedge clk); @(negedge clk);
      check("lat_e1_valid", int'(valid), 0);
      @(posedge clk); @(negedge clk);
      check("lat_e2_valid", int'(valid), 0);
      @(posedge clk); @(negedge clk);
      check("lat_e3_valid", int'(valid), 1);
      check("lat_e3_cmd",   int'(cmd), 125);
      idle(50);

      // Reset mid-pulse with the pin still high at release.
      @(posedge clk);
      #1 pwm = 1'b1;
      repeat (600) @(posedge clk);
      #1 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_mid_cmd",   int'(cmd), 0);
      check("rst_mid_cmd_f", int'(cmd_f), 0);
      check("rst_mid_lost",  int'(lost), 1);
      check("rst_mid_valid", int'(valid), 0);
      v0 = n_valid; e0 = n_err;
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (1000) @(posedge clk);
      #1 pwm = 1'b0;
      idle(200);
      @(negedge clk);
      check("partial_valid", n_valid - v0, 0);
      check("partial_err",   n_err - e0, 0);
      check("partial_lost",  int'(lost), 1);
      drive_pulse(1800, 1'b1);
      idle(50);
      @(negedge clk);
      check("after_partial_valid", n_valid - v0, 1);
      check("after_partial_cmd",   int'(cmd), 75);
      check("after_partial_cmd_f", int'(cmd_f), -75);
      check("after_partial_lost",  int'(lost), 0);
      check("never_valid_and_err", n_both, 0);

`ifdef PWM_DECODER_TIMEOUT_EN
      drive_pulse(2000, 1'b1);
      idle(100);
      @(negedge clk);
      check("wd_pre_cmd", int'(cmd), 125);
      v0 = n_valid;
      idle(48800);
      @(negedge clk);
      check("wd_before_to_lost", int'(lost), 0);
      check("wd_before_to_cmd",  int'(cmd), 125);
      idle(1200);
      @(negedge clk);
      check("wd_to_lost",  int'(lost), 1);
      check("wd_to_cmd",   int'(cmd), 0);
      check("wd_to_cmd_f", int'(cmd_f), 0);
      check("wd_to_valid", n_valid - v0, 0);
      drive_pulse(1500, 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         @(negedge clk);
         if (valid) begin
            seen = 1'b1;
            check("wd_clear_lost_same_cycle", int'(lost), 0);
            check("wd_clear_cmd", int'(cmd), 0);
         end
      end
      check("wd_clear_seen_valid", int'(seen), 1);
      idle(50);
      @(posedge clk);
      #1 pwm = 1'b1;
      repeat (300) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("wd_rst_lost", int'(lost), 1);
      check("wd_rst_cmd",  int'(cmd), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      pwm = 1'b0;
      idle(20);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
